frame_collector: RTL and testbench
==================================

FRAME_COLLECTOR -- requirements
Module: frame_collector

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, meaning FFT points per frame (power of 2, at least 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning signed bits per real and per imaginary component.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning a serial sample is present.
REQ-006 SHALL have port in_real / in_imag, input, DATA_WIDTH each, meaning the serial complex sample.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block can accept a sample.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning a complete frame is presented.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning the downstream bit reverser takes the frame.
REQ-010 SHALL have port out_real / out_imag, output, unpacked array [NUM_ENTRIES-1:0] of DATA_WIDTH, meaning the parallel frame in natural order.

Function
REQ-011 SHALL accept a sample on any rising edge where in_valid && in_ready.
REQ-012 SHALL have two frame banks (ping-pong), each in state FILL or FULL, plus registers wr_bank, rd_bank and wr_idx (log2 NUM_ENTRIES bits).
REQ-013 SHALL store the accepted sample at index wr_idx of bank wr_bank, then increment wr_idx.
REQ-014 SHALL, on acceptance at wr_idx = NUM_ENTRIES-1: mark wr_bank FULL, wrap wr_idx to 0, and toggle wr_bank.
REQ-015 SHALL drive in_ready = (bank[wr_bank] is FILL) combinationally from registered state; it SHALL never depend on in_valid.
REQ-016 SHALL drive out_valid = (bank[rd_bank] is FULL), and out_real/out_imag = contents of bank[rd_bank].
REQ-017 SHALL assert out_valid in the cycle immediately after the edge that accepts the last sample, when that bank is rd_bank (latency: 1 cycle).
REQ-018 SHALL hold out_valid and the frame data stable while out_valid && !out_ready.
REQ-019 SHALL, on an edge with out_valid && out_ready, mark bank[rd_bank] FILL and toggle rd_bank.
REQ-020 SHALL allow a fill of one bank and a drain of the other on the same edge; with both banks FULL and out_ready high, in_ready SHALL rise in the next cycle.
REQ-021 SHALL sustain one sample per cycle indefinitely when out_ready is held high.
REQ-022 SHALL ignore in_real/in_imag when the sample is not accepted.

Reset
REQ-023 SHALL, while reset=0 at a rising edge, set both banks to FILL, wr_bank=0, rd_bank=0, wr_idx=0; outputs then read in_ready=1, out_valid=0.
REQ-024 SHALL discard any partial or unconsumed frame on reset mid-operation; bank data need not be cleared.

Configuration
REQ-025 SHALL, with FRAME_LAST_CHECK_EN defined, add input in_last (1 bit) and output frame_err (1 bit, reset 0).
REQ-026 SHALL, with FRAME_LAST_CHECK_EN defined, set frame_err sticky high when an accepted sample has in_last=1 at wr_idx != NUM_ENTRIES-1; it SHALL then discard the partial bank and set wr_idx=0.
REQ-027 SHALL, with FRAME_LAST_CHECK_EN defined, set frame_err sticky high when an accepted sample has in_last=0 at wr_idx = NUM_ENTRIES-1; the frame still completes normally.
REQ-028 SHALL, without FRAME_LAST_CHECK_EN, have neither port and perform no framing check.

Structure
REQ-029 SHALL take NUM_ENTRIES, ENTRY_WIDTH (=$clog2(NUM_ENTRIES)) and DATA_WIDTH defaults, plus a complex_sample_t struct typedef (real, imag), from shared package ofdm_pkg.
REQ-030 SHALL instantiate two copies of sub-module frame_bank; each holds storage, a FULL flag, and write/free strobes.

Verification
REQ-031 SHALL cover: after reset, 8 back-to-back samples i=0..7 (real=i, imag=-i), out_ready=0 -> out_valid=1 in the cycle after sample 7; out_real[i]=i and out_imag[i]=-i.
REQ-032 SHALL cover: 16 samples with out_ready=0 -> in_ready=0 after the 16th sample; first frame held stable; a single out_ready pulse -> second frame shown next cycle and in_ready=1.
REQ-033 SHALL cover: continuous valid and out_ready=1 for 64 samples -> in_ready never drops; 8 frames delivered in order.
REQ-034 SHALL cover: reset=0 after 5 samples accepted -> next 8 samples form a clean frame with no stale data.
REQ-035 SHALL cover: with FRAME_LAST_CHECK_EN defined, in_last at index 3 -> frame_err=1 stays high; the next 8 samples (in_last on index 7) -> a correct frame.
REQ-036 SHALL cover: random in_valid/out_ready gaps (1000 samples) against a scoreboard -> zero mismatches and no lost frames.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM datapath types and default geometry.
// Read by frame_collector and frame_bank.
package ofdm_pkg;

  localparam int unsigned NUM_ENTRIES = 8;
  localparam int unsigned ENTRY_WIDTH = $clog2(NUM_ENTRIES);
  localparam int unsigned DATA_WIDTH  = 16;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } complex_sample_t;

  typedef enum logic {
    BankFill = 1'b0,
    BankFull = 1'b1
  } bank_state_e;

endpackage

// File: rtl/frame_bank.sv
// One frame buffer of the ping-pong pair: sample storage plus a FILL/FULL state.
// set_full and free never target the same bank on the same edge.
module frame_bank
  import ofdm_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = ofdm_pkg::NUM_ENTRIES,
  parameter int unsigned DATA_WIDTH  = ofdm_pkg::DATA_WIDTH,
  parameter int unsigned ENTRY_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ENTRY_WIDTH-1:0]       wr_idx,
  input  logic signed [DATA_WIDTH-1:0] wr_real,
  input  logic signed [DATA_WIDTH-1:0] wr_imag,
  input  logic                         set_full,
  input  logic                         free,
  output logic                         full,
  output logic signed [DATA_WIDTH-1:0] data_real [NUM_ENTRIES-1:0],
  output logic signed [DATA_WIDTH-1:0] data_imag [NUM_ENTRIES-1:0]
);

  bank_state_e                  state_q;
  logic signed [DATA_WIDTH-1:0] real_q [NUM_ENTRIES-1:0];
  logic signed [DATA_WIDTH-1:0] imag_q [NUM_ENTRIES-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BankFill;
    end else if (set_full) begin
      state_q <= BankFull;
    end else if (free) begin
      state_q <= BankFill;
    end
  end

  // Storage is deliberately left unreset; a FILL bank's contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      real_q[wr_idx] <= wr_real;
      imag_q[wr_idx] <= wr_imag;
    end
  end

  assign full      = (state_q == BankFull);
  assign data_real = real_q;
  assign data_imag = imag_q;

endmodule

// File: rtl/frame_collector.sv
// Serial-to-parallel frame collector with ping-pong banks feeding the bit reverser.
// Optional FRAME_LAST_CHECK_EN adds in_last / frame_err framing check.
module frame_collector
  import ofdm_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = ofdm_pkg::NUM_ENTRIES,
  parameter int unsigned DATA_WIDTH  = ofdm_pkg::DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  output logic                         in_ready,
`ifdef FRAME_LAST_CHECK_EN
  input  logic                         in_last,
  output logic                         frame_err,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real [NUM_ENTRIES-1:0],
  output logic signed [DATA_WIDTH-1:0] out_imag [NUM_ENTRIES-1:0]
);

  localparam int unsigned IdxWidth = $clog2(NUM_ENTRIES);

  logic                wr_bank_q;
  logic                rd_bank_q;
  logic [IdxWidth-1:0] wr_idx_q;

  logic [1:0] bank_full;
  logic [1:0] bank_wr;
  logic [1:0] bank_set_full;
  logic [1:0] bank_free;

  logic signed [DATA_WIDTH-1:0] bank_real [2][NUM_ENTRIES-1:0];
  logic signed [DATA_WIDTH-1:0] bank_imag [2][NUM_ENTRIES-1:0];

  logic accept;
  logic at_last;
  logic complete;
  logic drain;
  logic short_err;

  assign in_ready  = ~bank_full[wr_bank_q];
  assign out_valid = bank_full[rd_bank_q];

  assign accept   = in_valid & in_ready;
  assign at_last  = (wr_idx_q == IdxWidth'(NUM_ENTRIES - 1));
  assign complete = accept & at_last;
  assign drain    = out_valid & out_ready;

`ifdef FRAME_LAST_CHECK_EN
  logic long_err;
  logic frame_err_q;

  // Early in_last abandons the partial frame; a missing in_last only flags.
  assign short_err = accept & in_last & ~at_last;
  assign long_err  = accept & ~in_last & at_last;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
    end else if (short_err || long_err) begin
      frame_err_q <= 1'b1;
    end
  end
`else
  assign short_err = 1'b0;
`endif

  always_comb begin
    bank_wr                  = '0;
    bank_set_full            = '0;
    bank_free                = '0;
    bank_wr[wr_bank_q]       = accept;
    bank_set_full[wr_bank_q] = complete;
    bank_free[rd_bank_q]     = drain;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      if (accept) begin
        wr_idx_q <= short_err ? '0 : wr_idx_q + 1'b1;
      end
      if (complete) begin
        wr_bank_q <= ~wr_bank_q;
      end
      if (drain) begin
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .DATA_WIDTH  (DATA_WIDTH),
      .ENTRY_WIDTH (IdxWidth)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (bank_wr[b]),
      .wr_idx    (wr_idx_q),
      .wr_real   (in_real),
      .wr_imag   (in_imag),
      .set_full  (bank_set_full[b]),
      .free      (bank_free[b]),
      .full      (bank_full[b]),
      .data_real (bank_real[b]),
      .data_imag (bank_imag[b])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      out_real[i] = rd_bank_q ? bank_real[1][i] : bank_real[0][i];
      out_imag[i] = rd_bank_q ? bank_imag[1][i] : bank_imag[0][i];
    end
  end

endmodule

// File: tb/tb_frame_collector.sv
// Directed and scoreboarded bench for frame_collector (default 8 x 16-bit geometry).
// Define FRAME_LAST_CHECK_EN on both DUT and bench to exercise the framing check.
module tb_frame_collector;
  import ofdm_pkg::*;

  localparam int N  = 8;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real [N-1:0];
  logic signed [DW-1:0] out_imag [N-1:0];
  bit                   last_drv;
`ifdef FRAME_LAST_CHECK_EN
  logic                 in_last;
  logic                 frame_err;
`endif

  frame_collector #(
    .NUM_ENTRIES (N),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_ready  (in_ready),
`ifdef FRAME_LAST_CHECK_EN
    .in_last   (in_last),
    .frame_err (frame_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames_out = 0;
  bit err_exp = 1'b0;
  complex_sample_t part_q[$];
  complex_sample_t exp_q[$];

  typedef struct {
    bit v;
    int re;
    int im;
    bit rdy;
    bit last;
    bit exp_ir;
    bit exp_ov;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presented frame must be real[i]=base+i, imag[i]=-(base+i).
  task automatic chk_frame(input string name, input int base);
    logic signed [DW-1:0] er, ei;
    int bad_idx;
    bad_idx = -1;
    for (int i = N - 1; i >= 0; i--) begin
      er = DW'(base + i);
      ei = DW'(-(base + i));
      if (out_real[i] !== er || out_imag[i] !== ei) bad_idx = i;
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s: entry %0d got (%0d,%0d), expected (%0d,%0d)", name, bad_idx,
               out_real[bad_idx], out_imag[bad_idx], DW'(base + bad_idx), DW'(-(base + bad_idx)));
    end
  endtask

  task automatic drive(input bit v, input int re, input int im, input bit rdy, input bit last);
    in_valid  = v;
    in_real   = DW'(re);
    in_imag   = DW'(im);
    out_ready = rdy;
    last_drv  = last;
`ifdef FRAME_LAST_CHECK_EN
    in_last   = last;
`endif
  endtask

  // Check handshake outputs against the frame-count model, score the edge, then advance.
  task automatic tick();
    bit exp_ir, exp_ov;
    int bad_idx;
    complex_sample_t s;
    exp_ir = exp_q.size() < 2 * N;
    exp_ov = exp_q.size() >= N;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
`ifdef FRAME_LAST_CHECK_EN
    chk("frame_err", frame_err, err_exp);
`endif
    if (exp_ov && out_ready) begin
      bad_idx = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (out_real[i] !== exp_q[i].re || out_imag[i] !== exp_q[i].im) bad_idx = i;
      end
      checks++;
      if (bad_idx >= 0) begin
        errors++;
        $display("FAIL frame %0d entry %0d: got (%0d,%0d), expected (%0d,%0d)", frames_out,
                 bad_idx, out_real[bad_idx], out_imag[bad_idx], exp_q[bad_idx].re,
                 exp_q[bad_idx].im);
      end
      for (int i = 0; i < N; i++) void'(exp_q.pop_front());
      frames_out++;
    end
    if (in_valid && exp_ir) begin
      s.re = in_real;
      s.im = in_imag;
`ifdef FRAME_LAST_CHECK_EN
      if (in_last && part_q.size() != N - 1) begin
        err_exp = 1'b1;
        part_q.delete();
      end else begin
        if (!in_last && part_q.size() == N - 1) err_exp = 1'b1;
        part_q.push_back(s);
      end
`else
      part_q.push_back(s);
`endif
      if (part_q.size() == N) begin
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        part_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    part_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
`ifdef FRAME_LAST_CHECK_EN
    chk("reset_frame_err", frame_err, 0);
`endif
  endtask

  initial begin
    int acc, cyc, f0;
    bit v;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Basic fill: out_valid rises right after sample 7, then one drain pulse.
    for (int i = 0; i < N; i++) tbl[i] = '{1, i, -i, 0, (i == N - 1), 1, (i == N - 1)};
    tbl[8] = '{0, 0, 0, 0, 0, 1, 1};
    tbl[9] = '{0, 0, 0, 1, 0, 1, 0};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 9) chk_frame("basic_frame", 0);
      drive(tbl[k].v, tbl[k].re, tbl[k].im, tbl[k].rdy, tbl[k].last);
      tick();
      chk($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].exp_ir);
      chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].exp_ov);
    end

    // Both banks full: back-pressure, ignored input data, hold, single drain pulse.
    do_reset();
    for (int i = 0; i < 2 * N; i++) begin
      drive(1, 100 + i, -(100 + i), 0, (i % N == N - 1));
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h7abc, 16'h1234, 0, 1);
      tick();
    end
    chk_frame("full_hold", 100);
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("pulse_out_valid", out_valid, 1);
    chk("pulse_in_ready", in_ready, 1);
    chk_frame("pulse_second", 100 + N);
    drive(0, 0, 0, 1, 0);
    tick();

    // Streaming at one sample per cycle with the sink always ready.
    do_reset();
    f0 = frames_out;
    for (int i = 0; i < 8 * N; i++) begin
      drive(1, 300 + i, -(300 + i), 1, (i % N == N - 1));
      tick();
    end
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("stream_frames", frames_out - f0, 8);

    // Reset mid-frame discards the 5 partial samples.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 50 + i, 7, 0, 0);
      tick();
    end
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(1, 200 + i, -(200 + i), 0, (i == N - 1));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rst_mid_out_valid", out_valid, 1);
    chk_frame("rst_mid_frame", 200);

`ifdef FRAME_LAST_CHECK_EN
    // Early in_last at index 3 drops the partial frame and latches frame_err.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 400 + i, -(400 + i), 0, (i == 3));
      tick();
    end
    chk("early_last_err", frame_err, 1);
    chk("early_last_out_valid", out_valid, 0);
    for (int i = 0; i < N; i++) begin
      drive(1, 500 + i, -(500 + i), 0, (i == N - 1));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    chk("early_last_sticky", frame_err, 1);
    chk("recover_out_valid", out_valid, 1);
    chk_frame("recover_frame", 500);
`endif

    // Random gaps on both sides against the scoreboard.
    do_reset();
    f0 = frames_out;
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
            ($urandom_range(0, 2) != 0), (part_q.size() == N - 1));
      if (v && exp_q.size() < 2 * N) acc++;
      tick();
      cyc++;
    end
    chk("random_accepted", acc, 1000);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("random_frames", frames_out - f0, 125);
    chk("random_leftover", exp_q.size() + part_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
